// File: rtl/corr_fetch_pkg.sv
// Shared widths, FSM encoding and sideband layout for the correspondence fetch stage.
package corr_fetch_pkg;

  localparam int H_SIZE_BW    = 10;
  localparam int V_SIZE_BW    = 9;
  localparam int CLOUD_BW     = 16;
  localparam int CORR_RD_LAT  = 2;
  localparam int CORR_ADDR_BW = H_SIZE_BW + V_SIZE_BW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } corr_fetch_state_t;

  typedef struct packed {
    logic                    valid;
    logic                    inb;
    logic [CORR_ADDR_BW-1:0] src_idx;
    logic [CLOUD_BW-1:0]     tp_z;
  } corr_side_t;

  localparam int CORR_SIDE_BW = $bits(corr_side_t);

  // Unsigned absolute difference, one bit wider so it cannot wrap.
  function automatic logic [CLOUD_BW:0] abs_diff(input logic [CLOUD_BW-1:0] a,
                                                 input logic [CLOUD_BW-1:0] b);
    logic [CLOUD_BW:0] a_ext;
    logic [CLOUD_BW:0] b_ext;
    a_ext = {1'b0, a};
    b_ext = {1'b0, b};
    return (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
  endfunction

endpackage

// File: rtl/corr_delay_line.sv
// Fixed-depth shift register with synchronous clear; carries point sideband
// alongside the outstanding SRAM read.
module corr_delay_line #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_d;
      logic [WIDTH-1:0] stage_q;

      if (gi == 0) begin : g_first
        assign stage_d = i_d;
      end else begin : g_chain
        assign stage_d = g_stage[gi-1].stage_q;
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) stage_q <= '0;
        else       stage_q <= stage_d;
      end
    end
  endgenerate

  assign o_q = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/corr_fetch.sv
// Bounds-checks projected points, fetches reference depth from SRAM and tests
// depth consistency; one in-order result per accepted point, never stalls.
module corr_fetch
  import corr_fetch_pkg::*;
#(
  parameter int RD_LAT = CORR_RD_LAT,
  parameter int CNT_BW = H_SIZE_BW + V_SIZE_BW + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_frame_start,
  input  logic                    i_frame_end,
  input  logic                    i_valid,
  input  logic [H_SIZE_BW-1:0]    i_idx_x,
  input  logic [V_SIZE_BW-1:0]    i_idx_y,
  input  logic [CLOUD_BW-1:0]     i_cloud_z,
  input  logic [CORR_ADDR_BW-1:0] i_src_idx,
  input  logic [H_SIZE_BW-1:0]    r_width,
  input  logic [V_SIZE_BW-1:0]    r_height,
  input  logic [CLOUD_BW-1:0]     r_depth_th,
  output logic                    o_rd_en,
  output logic [CORR_ADDR_BW-1:0] o_rd_addr,
  input  logic [CLOUD_BW-1:0]     i_rd_data,
  output logic                    o_valid,
  output logic [CORR_ADDR_BW-1:0] o_src_idx,
  output logic                    o_match,
  output logic [CLOUD_BW-1:0]     o_ref_depth,
  output logic                    o_frame_done,
  output logic [CNT_BW-1:0]       o_corr_cnt,
  output logic [CNT_BW-1:0]       o_oob_cnt,
  output logic                    o_err
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;
  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT + 1);

  logic [1:0]              state_q, state_d;
  logic [2:0]              drain_cnt_q, drain_cnt_d;
  logic                    err_q, err_d;
  logic                    rd_en_q, rd_en_d;
  logic [CORR_ADDR_BW-1:0] rd_addr_q, rd_addr_d;
  logic                    valid_q, valid_d;
  logic                    match_q, match_d;
  logic [CLOUD_BW-1:0]     ref_depth_q, ref_depth_d;
  logic [CORR_ADDR_BW-1:0] src_idx_q, src_idx_d;
  logic [CNT_BW-1:0]       corr_cnt_q, corr_cnt_d;
  logic [CNT_BW-1:0]       oob_cnt_q, oob_cnt_d;

  logic                    start_ok;
  logic                    accept;
  logic                    err_now;
  logic                    inb;
  logic                    match_c;
  logic [CLOUD_BW:0]       diff;
  corr_side_t              side_in;
  corr_side_t              side_out;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    start_ok    = i_frame_start && (state_q == ST_IDLE);
    accept      = i_valid && (state_q == ST_RUN);
    err_now     = (i_valid && (state_q != ST_RUN))
               || (i_frame_start && (state_q != ST_IDLE))
               || (i_frame_end && (state_q != ST_RUN));
    case (state_q)
      ST_IDLE:  if (i_frame_start) state_d = ST_RUN;
      ST_RUN: begin
        if (i_frame_end) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      // Sized so the last accepted point has left the pipe before DONE.
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = ST_DONE;
        else                           drain_cnt_d = drain_cnt_q + 3'd1;
      end
      default:  state_d = ST_IDLE;
    endcase
    // A start from IDLE clears old errors but keeps any raised in the same cycle.
    err_d = (start_ok ? 1'b0 : err_q) | err_now;
  end

  always_comb begin
    inb       = (i_idx_x < r_width) && (i_idx_y < r_height);
    rd_en_d   = accept && inb;
    rd_addr_d = rd_en_d ? {i_idx_y, i_idx_x} : rd_addr_q;

    side_in.valid   = accept;
    side_in.inb     = accept && inb;
    side_in.src_idx = i_src_idx;
    side_in.tp_z    = i_cloud_z;
  end

  corr_delay_line #(
    .WIDTH  (CORR_SIDE_BW),
    .STAGES (RD_LAT + 1)
  ) u_side_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (side_in),
    .o_q   (side_out)
  );

  always_comb begin
    diff    = abs_diff(i_rd_data, side_out.tp_z);
    match_c = side_out.valid && side_out.inb && (i_rd_data != '0)
           && (diff <= {1'b0, r_depth_th});

    valid_d     = side_out.valid;
    match_d     = match_c;
    // Out-of-bounds points never issued a read, so the data bus is meaningless.
    ref_depth_d = (side_out.valid && side_out.inb) ? i_rd_data : '0;
    src_idx_d   = side_out.valid ? side_out.src_idx : '0;

    corr_cnt_d = corr_cnt_q;
    oob_cnt_d  = oob_cnt_q;
    if (start_ok) begin
      corr_cnt_d = '0;
      oob_cnt_d  = '0;
    end else begin
      if (match_c && !(&corr_cnt_q))
        corr_cnt_d = corr_cnt_q + 1'b1;
      if (side_out.valid && !side_out.inb && !(&oob_cnt_q))
        oob_cnt_d = oob_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      valid_q     <= 1'b0;
      match_q     <= 1'b0;
      ref_depth_q <= '0;
      src_idx_q   <= '0;
      corr_cnt_q  <= '0;
      oob_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      valid_q     <= valid_d;
      match_q     <= match_d;
      ref_depth_q <= ref_depth_d;
      src_idx_q   <= src_idx_d;
      corr_cnt_q  <= corr_cnt_d;
      oob_cnt_q   <= oob_cnt_d;
    end
  end

  assign o_rd_en      = rd_en_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_valid      = valid_q;
  assign o_match      = match_q;
  assign o_ref_depth  = ref_depth_q;
  assign o_src_idx    = src_idx_q;
  assign o_frame_done = (state_q == ST_DONE);
  assign o_corr_cnt   = corr_cnt_q;
  assign o_oob_cnt    = oob_cnt_q;
  assign o_err        = err_q;

endmodule

// File: doc/corr_fetch.md
# corr_fetch

Downstream neighbour of the projection stage. Takes each projected pixel index (u,v) with its transformed depth tp_z, bounds-checks it against the reference frame, issues a read to the external reference-depth SRAM, and tests depth consistency on return. It emits one result per input, in order, and keeps per-frame correspondence statistics. The block never stalls, so it matches the projection stage's fixed-latency, no-backpressure pipeline.

## Interface
Parameters:
- RD_LAT, 2, fixed SRAM read latency in cycles (1..4)
- CNT_BW, H_SIZE_BW+V_SIZE_BW+1, statistic counter width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_frame_start  in  1  one-cycle pulse; opens a frame
- i_frame_end  in  1  one-cycle pulse; closes a frame
- i_valid  in  1  projected point valid
- i_idx_x  in  H_SIZE_BW  projected u
- i_idx_y  in  V_SIZE_BW  projected v
- i_cloud_z  in  CLOUD_BW  tp_z, aligned with i_idx_*
- i_src_idx  in  H_SIZE_BW+V_SIZE_BW  source pixel id, passed through unchanged
- r_width  in  H_SIZE_BW  active image width
- r_height  in  V_SIZE_BW  active image height
- r_depth_th  in  CLOUD_BW  max |ref_depth − tp_z| for a match
- o_rd_en  out  1  SRAM read strobe
- o_rd_addr  out  H_SIZE_BW+V_SIZE_BW  {v,u}
- i_rd_data  in  CLOUD_BW  reference depth, valid RD_LAT cycles after o_rd_en
- o_valid  out  1  result valid
- o_src_idx  out  H_SIZE_BW+V_SIZE_BW  passed-through id
- o_match  out  1  correspondence accepted
- o_ref_depth  out  CLOUD_BW  returned depth; 0 if not read
- o_frame_done  out  1  one-cycle pulse after drain
- o_corr_cnt  out  CNT_BW  matches this frame
- o_oob_cnt  out  CNT_BW  out-of-bounds points this frame
- o_err  out  1  sticky protocol error; cleared by i_frame_start in IDLE

## Operation
- Reset: all outputs 0, FSM IDLE, all pipeline valids cleared. A read already in flight is ignored on return.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE→RUN on i_frame_start. Entering RUN clears both counters and o_err.
  - RUN→DRAIN on i_frame_end.
  - DRAIN holds RD_LAT+2 cycles, then goes to DONE.
  - DONE lasts 1 cycle, asserts o_frame_done, then returns to IDLE.
- Acceptance:
  - i_valid is accepted only in RUN, including the i_frame_end cycle.
  - i_valid in IDLE, DRAIN or DONE is dropped and sets o_err.
  - i_frame_start outside IDLE is ignored and sets o_err.
  - i_frame_end outside RUN is ignored and sets o_err.
- Bounds check on an accepted point:
  - inb = (i_idx_x < r_width) && (i_idx_y < r_height), unsigned.
  - The upstream saturated all-ones index for negative coordinates therefore fails the check.
  - inb=0: no SRAM read, o_oob_cnt increments.
- Match rule: o_match = inb && ref≠0 && |ref − tp_z| ≤ r_depth_th.
  - Difference is computed in CLOUD_BW+1 bits, unsigned. A depth of 0 means invalid.
  - o_corr_cnt increments on each match.
- Counters saturate at all-ones. They hold their value after DONE until the next frame start.
- Output order equals input order. There is exactly one o_valid per accepted input, including out-of-bounds points (o_match=0, o_ref_depth=0).

## Timing
- Accepted input at cycle t:
  - o_rd_en and o_rd_addr are registered at t+1.
  - i_rd_data is sampled at t+1+RD_LAT.
  - o_valid, o_match, o_ref_depth and o_src_idx are registered at t+2+RD_LAT.
- Latency is RD_LAT+2. Throughput is one point per cycle with no bubbles.
- o_rd_en drops back to 0 the cycle after the last in-bounds point.
- Counters update in the same cycle as the corresponding o_valid.
- o_frame_done rises one cycle after the last o_valid of the frame. On that cycle o_corr_cnt and o_oob_cnt are final.
- Simultaneous i_frame_start and i_frame_end in IDLE: start wins and end sets o_err.
- Reset mid-frame: the next cycle is IDLE with o_valid=0. No o_frame_done is produced for the aborted frame.

## Structure
- RgbdVoConfigPk additions:
  - typedef enum corr_fetch_state_t {IDLE, RUN, DRAIN, DONE}
  - constant CORR_RD_LAT = 2
  - constant CORR_ADDR_BW = H_SIZE_BW+V_SIZE_BW
- Sub-module corr_delay_line: parameterised width/stage shift register with synchronous active-high reset. Used for the valid/inb/src_idx/tp_z sideband over RD_LAT+1 stages.
- Bounds check, compare and counters are inline.

## Test plan
- Basic path: RD_LAT=2, width 640×480, r_depth_th=10. Frame start, then point (100,50), z=1000, SRAM returns 1005 → o_rd_addr={50,100} one cycle after the point; o_valid 4 cycles after the point with o_match=1, o_ref_depth=1005, o_corr_cnt=1.
- Out of bounds: points (640,0), (0,480) and (all-ones, all-ones) → no o_rd_en; three o_valid with o_match=0, o_ref_depth=0; o_oob_cnt=3.
- Depth reject: ref=0 → o_match=0. ref=1011 with z=1000 → o_match=0. ref=990 with z=1000 → o_match=1.
- Back-to-back stream: 1000 consecutive valid points, frame end on the last one → 1000 in-order o_valid; o_frame_done exactly RD_LAT+3 cycles after the end; counts correct.
- Protocol errors: i_valid in IDLE, and a second frame start in RUN → o_err=1, no o_valid for the dropped point; o_err cleared at the next start from IDLE.
- Reset mid-frame: i_rst asserted with 3 points in flight → zero o_valid afterwards, outputs 0, FSM IDLE; a following normal frame behaves correctly.
